cvtsw_sched: RTL and testbench
==============================

Name: cvtsw_sched

Overview:
- Round-robin scheduler that shares one combinational `cvtsw` instance (signed integer → IEEE-754 binary, selectable rounding attribute, inexact flag) among NREQ requesters.
- Each requester uses a valid/ready request channel. Results return on one shared valid/ready channel, tagged with the requester ID.
- Keeps a per-requester sticky inexact flag (IEEE-754 exception accumulation).
- Sits between the integer pipelines and the FP register file.

Parameters:
- INTn, 32, integer operand width passed to `cvtsw`
- NEXP, 8, result exponent width passed to `cvtsw`
- NSIG, 23, result significand width passed to `cvtsw`
- NREQ, 4, number of requesters (2..16)
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ
- LAST_RA comes from ieee-754-flags.v and is not overridden; the rounding-attribute vector is LAST_RA+1 bits, one-hot

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_w  in  NREQ*INTn  packed signed operands; requester k uses bits [k*INTn +: INTn]
- req_ra  in  NREQ*(LAST_RA+1)  packed one-hot rounding attributes, packed the same way
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer accepts the result
- out_s  out  NEXP+NSIG+1  converted value
- out_inexact  out  1  inexact flag for out_s
- out_id  out  IDW  requester that issued this result
- sticky_inexact  out  NREQ  per-requester accumulated inexact flags
- sticky_clr  in  NREQ  per-requester synchronous clear of sticky_inexact

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_s=0, out_inexact=0, out_id=0
  - sticky_inexact=0
  - round-robin pointer rr_ptr=0
  - req_ready=0 while reset is asserted
- slot_free = !out_valid | out_ready.
- Arbitration (combinational, registered pointer):
  - When slot_free, grant the first k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[k]=1 for the granted k only. When slot_free=0, req_ready is all zero.
  - req_ready never depends on out_valid of the same requester, and never grants when req_valid is low.
- Transfer: request k is accepted on a cycle where req_valid[k] & req_ready[k].
- Pointer update: on each accepted transfer, rr_ptr ← (k+1) mod NREQ. Otherwise rr_ptr holds.
  - Wrap-around: grant to NREQ-1 sets rr_ptr=0.
  - Values of rr_ptr ≥ NREQ are unreachable.
- Datapath:
  - A mux selects req_w/req_ra of the granted k into the single `cvtsw` instance.
  - On an accept edge, the results are captured: out_s ← s, out_inexact ← inexact, out_id ← k, out_valid ← 1.
  - Latency: exactly 1 cycle from accept to out_valid.
  - Throughput: 1 result/cycle while out_ready is held high.
- Output hold:
  - While out_valid & !out_ready, out_s, out_inexact and out_id are stable and no request is accepted.
  - If out_ready=1 and no request is accepted, out_valid ← 0 and the data fields hold their last values.
  - Simultaneous drain and accept: the new result replaces the old one, and out_valid stays 1.
- Rounding attribute: forwarded unmodified. A non-one-hot ra is a protocol violation; the result is don't-care but the handshake remains correct.
- Sticky flags:
  - sticky_inexact[k] is set on the cycle that out_valid & out_ready & out_inexact & out_id==k, i.e. at consumption, not at conversion.
  - sticky_clr[k] clears bit k.
  - Set and clear in the same cycle: set wins.
- Requester behaviour: a requester may drop req_valid without being granted; no state is retained for it.
- Reset mid-operation: an in-flight result is discarded, out_valid drops immediately (asynchronously), and rr_ptr restarts at 0.

Test Plan:
- Single requester 0, w=1, ra=roundTiesToEven, out_ready=1 → next cycle: out_s=0x3f800000, out_inexact=0, out_id=0; w=-1 → 0xbf800000.
- Requester 2, w=0x7fffffff, the four attributes in turn:
  - roundTiesToEven → 0x4f000000, inexact=1
  - roundTowardZero → 0x4effffff, inexact=1
  - roundTowardNegative → 0x4effffff, inexact=1
  - roundTowardPositive → 0x4f000000, inexact=1
  - sticky_inexact[2]=1
- All four requesters valid every cycle, out_ready=1 → out_id sequence 0,1,2,3,0,…, one per cycle; each requester gets exactly one grant per 4 cycles.
- Backpressure: out_ready=0 for 5 cycles with a pending w=0x80000000 → out_valid=1 and out_s=0xcf000000 held stable; req_ready all 0; after out_ready=1, the next requester is granted in that same cycle.
- w=0x01000001:
  - roundTiesToEven → 0x4b800000, inexact=1
  - roundTowardPositive → 0x4b800001
  - sticky_clr asserted the same cycle as the set → sticky bit stays 1
  - sticky_clr alone → sticky bit 0
- Assert rst_n low while out_valid=1 → out_valid=0 immediately, sticky_inexact=0; after release, requester 0 is granted first.

Source files
------------

// File: rtl/cvtsw_sched.sv
// Round-robin scheduler sharing one signed-integer to IEEE-754 converter among NREQ
// requesters; results are registered, tagged with the requester ID, and feed sticky inexact flags.
`timescale 1ns/1ps

module cvtsw #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 23,
  parameter int NRA  = 5
) (
  input  logic [INTn-1:0]    i_w,
  input  logic [NRA-1:0]     i_ra,
  output logic [NEXP+NSIG:0] o_s,
  output logic               o_inexact
);
  localparam int roundTiesToEven     = 0;
  localparam int roundTiesToAway     = 1;
  localparam int roundTowardPositive = 2;
  localparam int roundTowardNegative = 3;
  localparam int roundTowardZero     = 4;

  localparam int EW = INTn + NSIG + 2;
  localparam logic [NEXP:0]   BIAS     = {2'b00, {(NEXP-1){1'b1}}};
  localparam logic [NEXP:0]   EXP_INF  = {1'b0, {NEXP{1'b1}}};
  localparam logic [NEXP-1:0] EXP_MAXF = {{(NEXP-1){1'b1}}, 1'b0};

  logic                 w_sign;
  logic [INTn-1:0]      w_mag;
  int                   w_lead;
  logic [EW-1:0]        w_norm;
  logic                 w_isZero;
  logic [NSIG-1:0]      w_frac;
  logic                 w_guard;
  logic                 w_stick;
  logic                 w_up;
  logic                 w_toMax;
  logic [NEXP:0]        w_expBase;
  logic [NEXP+NSIG:0]   w_sum;
  logic                 w_ovf;

  // Normalise the magnitude so its leading one sits in the top bit; everything
  // below the kept significand becomes guard and sticky for rounding.
  always_comb begin
    w_sign = i_w[INTn-1];
    w_mag  = w_sign ? (~i_w + 1'b1) : i_w;
    w_lead = 0;
    for (int i = 0; i < INTn; i++) begin
      if (w_mag[i]) w_lead = i;
    end
    w_norm    = {w_mag, {(NSIG+2){1'b0}}} << (INTn - 1 - w_lead);
    w_isZero  = !w_norm[EW-1];
    w_frac    = w_norm[EW-2 -: NSIG];
    w_guard   = w_norm[EW-2-NSIG];
    w_stick   = |w_norm[EW-3-NSIG:0];
    w_up      = (i_ra[roundTiesToEven]     & w_guard & (w_stick | w_frac[0]))
              | (i_ra[roundTiesToAway]     & w_guard)
              | (i_ra[roundTowardPositive] & !w_sign & (w_guard | w_stick))
              | (i_ra[roundTowardNegative] &  w_sign & (w_guard | w_stick));
    w_toMax   = i_ra[roundTowardZero]
              | (i_ra[roundTowardPositive] &  w_sign)
              | (i_ra[roundTowardNegative] & !w_sign);
    w_expBase = (NEXP+1)'(w_lead) + BIAS;
    w_sum     = {w_expBase, w_frac} + (NEXP+NSIG+1)'(w_up);
    w_ovf     = w_sum[NSIG +: NEXP+1] >= EXP_INF;

    o_s       = '0;
    o_inexact = 1'b0;
    if (w_isZero) begin
      o_s       = '0;
      o_inexact = 1'b0;
    end else if (w_ovf) begin
      o_s       = w_toMax ? {w_sign, EXP_MAXF, {NSIG{1'b1}}}
                          : {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      o_inexact = 1'b1;
    end else begin
      o_s       = {w_sign, w_sum[NEXP+NSIG-1:0]};
      o_inexact = w_guard | w_stick;
    end
  end
endmodule

module cvtsw_sched #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 23,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  localparam int LAST_RA = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*INTn-1:0]        req_w,
  input  logic [NREQ*(LAST_RA+1)-1:0] req_ra,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NEXP+NSIG:0]          out_s,
  output logic                        out_inexact,
  output logic [IDW-1:0]              out_id,
  output logic [NREQ-1:0]             sticky_inexact,
  input  logic [NREQ-1:0]             sticky_clr
);
  localparam int NRA = LAST_RA + 1;

  logic [IDW-1:0]     r_rrPtr;
  logic               r_outValid;
  logic [NEXP+NSIG:0] r_outS;
  logic               r_outInexact;
  logic [IDW-1:0]     r_outId;
  logic [NREQ-1:0]    r_sticky;

  logic               w_slotFree;
  logic               w_found;
  logic               w_accept;
  logic [IDW-1:0]     w_grantId;
  logic [IDW-1:0]     w_nextPtr;
  logic [INTn-1:0]    w_selW;
  logic [NRA-1:0]     w_selRa;
  logic [NEXP+NSIG:0] w_s;
  logic               w_inexact;
  logic [NREQ-1:0]    w_stickySet;

  assign w_slotFree = !r_outValid || out_ready;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found   = 1'b0;
    w_grantId = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!w_found && req_valid[(int'(r_rrPtr) + off) % NREQ]) begin
        w_found   = 1'b1;
        w_grantId = IDW'((int'(r_rrPtr) + off) % NREQ);
      end
    end
  end

  assign req_ready = (rst_n && w_slotFree && w_found) ? (NREQ'(1) << w_grantId) : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_nextPtr = (int'(w_grantId) == NREQ - 1) ? '0 : w_grantId + 1'b1;

  assign w_selW  = req_w[int'(w_grantId)*INTn +: INTn];
  assign w_selRa = req_ra[int'(w_grantId)*NRA +: NRA];

  cvtsw #(
    .INTn(INTn),
    .NEXP(NEXP),
    .NSIG(NSIG),
    .NRA (NRA)
  ) u_cvtsw (
    .i_w      (w_selW),
    .i_ra     (w_selRa),
    .o_s      (w_s),
    .o_inexact(w_inexact)
  );

  // A drain without a new accept only drops valid; data fields keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr      <= '0;
      r_outValid   <= 1'b0;
      r_outS       <= '0;
      r_outInexact <= 1'b0;
      r_outId      <= '0;
    end else if (w_accept) begin
      r_rrPtr      <= w_nextPtr;
      r_outValid   <= 1'b1;
      r_outS       <= w_s;
      r_outInexact <= w_inexact;
      r_outId      <= w_grantId;
    end else if (out_ready) begin
      r_outValid   <= 1'b0;
    end
  end

  // Flags accumulate when the consumer takes the result, and a set beats a same-cycle clear.
  assign w_stickySet = (r_outValid && out_ready && r_outInexact) ? (NREQ'(1) << r_outId) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~sticky_clr) | w_stickySet;
    end
  end

  assign out_valid      = r_outValid;
  assign out_s          = r_outS;
  assign out_inexact    = r_outInexact;
  assign out_id         = r_outId;
  assign sticky_inexact = r_sticky;
endmodule

// File: tb/tb_cvtsw_sched.sv
// Directed and randomized bench for cvtsw_sched against a cycle-level model that
// converts with plain integer arithmetic and arbitrates from the round-robin rule.
`timescale 1ns/1ps

module tb_cvtsw_sched;
  localparam int NREQ = 4;
  localparam int NRA  = 5;
  localparam int RNE = 0, RNA = 1, RUP = 2, RDN = 3, RTZ = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_w = '0;
  logic [NREQ*NRA-1:0] req_ra = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [31:0]        out_s;
  logic               out_inexact;
  logic [1:0]         out_id;
  logic [NREQ-1:0]    sticky_inexact;
  logic [NREQ-1:0]    sticky_clr = '0;

  always #5 clk = ~clk;

  cvtsw_sched #(
    .INTn(32), .NEXP(8), .NSIG(23), .NREQ(NREQ), .IDW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_w(req_w), .req_ra(req_ra),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_inexact(out_inexact), .out_id(out_id),
    .sticky_inexact(sticky_inexact), .sticky_clr(sticky_clr)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0]     tw [NREQ];
  int              tra [NREQ];
  logic [NREQ-1:0] tv = '0;
  logic [NREQ-1:0] tclr = '0;
  logic            outReady = 1'b0;

  int              mPtr;
  logic            mValid;
  logic [31:0]     mS;
  logic            mInex;
  int              mId;
  logic [NREQ-1:0] mSticky;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < NREQ; k++) begin
      req_w[k*32 +: 32]   = tw[k];
      req_ra[k*NRA +: NRA] = NRA'(1 << tra[k]);
    end
    req_valid  = tv;
    out_ready  = outReady;
    sticky_clr = tclr;
  endtask

  task automatic clearReq();
    tv   = '0;
    tclr = '0;
  endtask

  // Reference conversion: scale the magnitude down to 24 significant bits by
  // integer division and round on the remainder.
  function automatic void refConvert(input logic [31:0] w, input int mode,
                                     output logic [31:0] s, output logic inex);
    longint v, mag, scale, q, rem, half;
    int e;
    logic sgn, up;
    v   = longint'($signed(w));
    sgn = v < 0;
    mag = sgn ? -v : v;
    if (mag == 0) begin
      s = '0; inex = 1'b0;
      return;
    end
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      scale = 1; q = mag << (23 - e); rem = 0;
    end else begin
      scale = longint'(1) << (e - 23); q = mag / scale; rem = mag % scale;
    end
    half = scale / 2;
    inex = rem != 0;
    case (mode)
      RNE:     up = (rem != 0) && ((rem > half) || (rem == half && (q % 2) == 1));
      RNA:     up = (rem != 0) && (rem >= half);
      RUP:     up = !sgn && rem != 0;
      RDN:     up = sgn && rem != 0;
      default: up = 1'b0;
    endcase
    q = q + (up ? 1 : 0);
    if (q == (longint'(1) << 24)) begin
      q = q >> 1; e++;
    end
    s = {sgn, 8'(e + 127), q[22:0]};
  endfunction

  function automatic int pickGrant(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 0; off < NREQ; off++) begin
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check arbitration before the edge, advance the model at the edge,
  // then check every registered output just after it.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] expReady, nextSticky;
    @(negedge clk);
    g = (!mValid || outReady) ? pickGrant(tv, mPtr) : -1;
    expReady = (g >= 0) ? NREQ'(1 << g) : '0;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    @(posedge clk);
    nextSticky = mSticky & ~tclr;
    if (mValid && outReady && mInex) nextSticky[mId] = 1'b1;
    if (g >= 0) begin
      refConvert(tw[g], tra[g], mS, mInex);
      mId = g; mValid = 1'b1; mPtr = (g + 1) % NREQ;
    end else if (outReady) begin
      mValid = 1'b0;
    end
    mSticky = nextSticky;
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("out_s", out_s, mS);
    checkOutput("out_inexact", 32'(out_inexact), 32'(mInex));
    checkOutput("out_id", 32'(out_id), 32'(mId));
    checkOutput("sticky", 32'(sticky_inexact), 32'(mSticky));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    mPtr = 0; mValid = 1'b0; mS = '0; mInex = 1'b0; mId = 0; mSticky = '0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_s", out_s, 32'd0);
    checkOutput("rst_out_id", 32'(out_id), 32'd0);
    checkOutput("rst_sticky", 32'(sticky_inexact), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] randW();
    logic [31:0] specials [7];
    specials = '{32'h0, 32'h1, 32'hffffffff, 32'h7fffffff, 32'h80000000, 32'h01000001, 32'h00ffffff};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($signed($urandom_range(0, 200)) - 100);
      2:       return specials[$urandom_range(0, 6)];
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    int modes [4];
    logic [31:0] exps [4];
    int cnt [NREQ];

    for (int k = 0; k < NREQ; k++) begin
      tw[k] = '0; tra[k] = RNE;
    end
    applyStimulus();
    #1;
    doReset();

    $display("[TB] single requester conversions");
    clearReq(); outReady = 1'b1;
    tv[0] = 1'b1; tw[0] = 32'h1; tra[0] = RNE;
    applyStimulus(); cycle();
    checkOutput("one_s", out_s, 32'h3f800000);
    checkOutput("one_inexact", 32'(out_inexact), 32'd0);
    checkOutput("one_id", 32'(out_id), 32'd0);
    tw[0] = 32'hffffffff;
    applyStimulus(); cycle();
    checkOutput("minus_one_s", out_s, 32'hbf800000);

    $display("[TB] rounding attributes on 0x7fffffff");
    clearReq(); tv[2] = 1'b1; tw[2] = 32'h7fffffff;
    modes = '{RNE, RTZ, RDN, RUP};
    exps  = '{32'h4f000000, 32'h4effffff, 32'h4effffff, 32'h4f000000};
    for (int i = 0; i < 4; i++) begin
      tra[2] = modes[i];
      applyStimulus(); cycle();
      checkOutput($sformatf("max_ra%0d_s", modes[i]), out_s, exps[i]);
      checkOutput($sformatf("max_ra%0d_inexact", modes[i]), 32'(out_inexact), 32'd1);
    end
    clearReq(); applyStimulus(); cycle();
    checkOutput("sticky2_set", 32'(sticky_inexact[2]), 32'd1);

    $display("[TB] round-robin with all requesters valid");
    doReset();
    for (int k = 0; k < NREQ; k++) begin
      tw[k] = 32'(k + 10); tra[k] = RNE; cnt[k] = 0;
    end
    tv = '1; outReady = 1'b1;
    applyStimulus();
    for (int i = 0; i < 8; i++) begin
      cycle();
      checkOutput($sformatf("rr_id_%0d", i), 32'(out_id), 32'(i % NREQ));
      cnt[out_id]++;
    end
    for (int k = 0; k < NREQ; k++) checkOutput($sformatf("rr_count_%0d", k), 32'(cnt[k]), 32'd2);

    $display("[TB] backpressure");
    clearReq(); tv[1] = 1'b1; tw[1] = 32'h80000000; tra[1] = RNE;
    applyStimulus(); cycle();
    checkOutput("bp_first_s", out_s, 32'hcf000000);
    tv = '1; outReady = 1'b0;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_s", out_s, 32'hcf000000);
      checkOutput("bp_ready_zero", 32'(req_ready), 32'd0);
    end
    outReady = 1'b1;
    applyStimulus();
    #1;
    checkOutput("bp_release_grant", 32'(req_ready), 32'h4);
    cycle();

    $display("[TB] sticky set/clear on 0x01000001");
    clearReq(); tv[3] = 1'b1; tw[3] = 32'h01000001; tra[3] = RNE;
    applyStimulus(); cycle();
    checkOutput("tie_rne_s", out_s, 32'h4b800000);
    checkOutput("tie_rne_inexact", 32'(out_inexact), 32'd1);
    checkOutput("tie_sticky_pending", 32'(sticky_inexact[3]), 32'd0);
    tra[3] = RUP; tclr[3] = 1'b1;
    applyStimulus(); cycle();
    checkOutput("tie_rup_s", out_s, 32'h4b800001);
    checkOutput("sticky_set_wins", 32'(sticky_inexact[3]), 32'd1);
    clearReq(); applyStimulus(); cycle();
    tclr[3] = 1'b1; applyStimulus(); cycle();
    checkOutput("sticky_clear", 32'(sticky_inexact[3]), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        tw[k]  = randW();
        tra[k] = $urandom_range(0, 4);
      end
      tv       = NREQ'($urandom);
      outReady = $urandom_range(0, 3) != 0;
      tclr     = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
      applyStimulus(); cycle();
    end

    $display("[TB] reset while a result is pending");
    clearReq(); tv[1] = 1'b1; tw[1] = 32'h12345; outReady = 1'b0;
    applyStimulus(); cycle();
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    doReset();
    tv = '1; outReady = 1'b1;
    applyStimulus();
    #1;
    checkOutput("post_reset_grant", 32'(req_ready), 32'h1);
    cycle();
    checkOutput("post_reset_id", 32'(out_id), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
